// File: rtl/wb_gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_pkg                                                        |
// | Purpose  : Shared register-map constants, register enum and byte-lane      |
// |            helper for the Wishbone GPIO block.                             |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package gpio_pkg;

  // Word offsets, decoded from adr[5:2]
  localparam logic [3:0] GPIO_DATA_OUT = 4'd0;
  localparam logic [3:0] GPIO_DIR      = 4'd1;
  localparam logic [3:0] GPIO_DATA_IN  = 4'd2;
  localparam logic [3:0] GPIO_SET      = 4'd3;
  localparam logic [3:0] GPIO_CLR      = 4'd4;
  localparam logic [3:0] GPIO_TGL      = 4'd5;
  localparam logic [3:0] GPIO_RISE_EN  = 4'd6;
  localparam logic [3:0] GPIO_FALL_EN  = 4'd7;
  localparam logic [3:0] GPIO_IRQ_PEND = 4'd8;

  typedef enum logic [3:0] {
    REG_DATA_OUT = 4'd0,
    REG_DIR      = 4'd1,
    REG_DATA_IN  = 4'd2,
    REG_SET      = 4'd3,
    REG_CLR      = 4'd4,
    REG_TGL      = 4'd5,
    REG_RISE_EN  = 4'd6,
    REG_FALL_EN  = 4'd7,
    REG_IRQ_PEND = 4'd8
  } gpio_reg_e;

  // Zero every byte of 'data' whose lane select is low.
  function automatic logic [31:0] gpio_sel_mask(input logic [31:0] data,
                                                input logic [3:0]  sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = sel[b] ? data[8*b +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_gpio_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_gpio_if                                                      |
// | Purpose  : Wishbone B4 pipelined bus bundle for the GPIO slave.            |
// | Signals  : cyc, stb, we, adr[31:0], dat_w[31:0], sel[3:0] (master->slave) |
// |            dat_r[31:0], ack, stall, err             (slave->master)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface wb_gpio_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (output cyc, stb, we, adr, dat_w, sel,
                  input  dat_r, ack, stall, err);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                  output dat_r, ack, stall, err);
endinterface
`default_nettype wire

// File: rtl/wb_gpio_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_sync_edge                                                  |
// | Purpose  : Multi-flop input synchroniser with enabled edge detection.      |
// | Ports    : clk_i, rst_i        clock / async active-high reset             |
// |            pin_i[W]            asynchronous pin inputs                     |
// |            rise_en_i, fall_en_i per-pin edge enables                       |
// |            data_in_o[W]        synchronised pin value                      |
// |            rise_o, fall_o      single-cycle enabled edge strobes           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gpio_sync_edge #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  output logic [WIDTH-1:0] data_in_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign data_in_o = sync_q[SYNC_STAGES-1];
  // Edges are qualified by the enable in the same cycle; a disabled edge is lost.
  assign rise_o    =  data_in_o & ~prev_q & rise_en_i;
  assign fall_o    = ~data_in_o &  prev_q & fall_en_i;

endmodule
`default_nettype wire

// File: rtl/wb_gpio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_gpio                                                         |
// | Purpose  : Wishbone B4 pipelined GPIO slave: output/direction registers,   |
// |            atomic set/clear/toggle, synchronised inputs, edge interrupts.  |
// | Ports    : clk_i, rst_i   clock / async active-high reset                  |
// |            wb            Wishbone slave modport (stall/err tied 0)         |
// |            gpio_i[W]     asynchronous pin inputs                           |
// |            gpio_o[W]     output data, gpio_oe_o[W] output enable           |
// |            irq_o         registered OR of pending interrupt bits           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_gpio
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 16,  // 1..32
  parameter int               SYNC_STAGES = 2,   // >= 2
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_gpio_if.slave         wb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  logic             w_acc, w_wr, w_rd;
  logic [3:0]       w_idx;
  logic [31:0]      w_wdat_full, w_bmask_full, w_rdat;
  logic [WIDTH-1:0] w_wdat, w_bmask, w_w1c;
  logic [WIDTH-1:0] w_data_in, w_rise, w_fall;

  logic [WIDTH-1:0] dout_q, dout_d, dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             ack_q, irq_q;
  logic [31:0]      rdat_q;

  // Stall is never raised, so every cyc&stb cycle is an accepted access.
  assign w_acc = wb.cyc & wb.stb;
  assign w_wr  = w_acc &  wb.we;
  assign w_rd  = w_acc & ~wb.we;
  assign w_idx = wb.adr[5:2];

  assign w_wdat_full  = gpio_sel_mask(wb.dat_w, wb.sel);
  assign w_bmask_full = gpio_sel_mask(32'hFFFF_FFFF, wb.sel);
  assign w_wdat       = w_wdat_full[WIDTH-1:0];
  assign w_bmask      = w_bmask_full[WIDTH-1:0];

  // Only adr[5:2] selects a register; the crossbar has already decoded the rest.
  logic unused_adr;
  assign unused_adr = ^{wb.adr[31:6], wb.adr[1:0]};

  if (WIDTH < 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{w_wdat_full[31:WIDTH], w_bmask_full[31:WIDTH]};
  end

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pin_i     (gpio_i),
    .rise_en_i (rise_en_q),
    .fall_en_i (fall_en_q),
    .data_in_o (w_data_in),
    .rise_o    (w_rise),
    .fall_o    (w_fall)
  );

  always_comb begin
    dout_d    = dout_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w_w1c     = '0;
    if (w_wr) begin
      case (w_idx)
        GPIO_DATA_OUT: dout_d    = (dout_q    & ~w_bmask) | w_wdat;
        GPIO_DIR:      dir_d     = (dir_q     & ~w_bmask) | w_wdat;
        GPIO_SET:      dout_d    = dout_q |  w_wdat;
        GPIO_CLR:      dout_d    = dout_q & ~w_wdat;
        GPIO_TGL:      dout_d    = dout_q ^  w_wdat;
        GPIO_RISE_EN:  rise_en_d = (rise_en_q & ~w_bmask) | w_wdat;
        GPIO_FALL_EN:  fall_en_d = (fall_en_q & ~w_bmask) | w_wdat;
        GPIO_IRQ_PEND: w_w1c     = w_wdat;
        default:       ;
      endcase
    end
    // A new edge in the same cycle as its clear keeps the bit set.
    pend_d = (pend_q & ~w_w1c) | w_rise | w_fall;
  end

  always_comb begin
    w_rdat = '0;
    case (w_idx)
      GPIO_DATA_OUT: w_rdat[WIDTH-1:0] = dout_q;
      GPIO_DIR:      w_rdat[WIDTH-1:0] = dir_q;
      GPIO_DATA_IN:  w_rdat[WIDTH-1:0] = w_data_in;
      GPIO_RISE_EN:  w_rdat[WIDTH-1:0] = rise_en_q;
      GPIO_FALL_EN:  w_rdat[WIDTH-1:0] = fall_en_q;
      GPIO_IRQ_PEND: w_rdat[WIDTH-1:0] = pend_q;
      default:       w_rdat = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q    <= OUT_RESET;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      ack_q     <= w_acc;
      // Data bus is held at zero outside read acks.
      rdat_q    <= w_rd ? w_rdat : 32'd0;
      irq_q     <= |pend_q;
    end
  end

  assign wb.ack    = ack_q;
  assign wb.dat_r  = rdat_q;
  assign wb.stall  = 1'b0;
  assign wb.err    = 1'b0;
  assign gpio_o    = dout_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_gpio                                                      |
// | Purpose  : Directed self-checking bench for wb_gpio with an ack scoreboard.|
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wb_gpio;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] gpio_in = '0;
  logic [15:0] gpio_out, gpio_oe;
  logic        irq;
  int          cyc_n = 0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic        rd;
    logic [31:0] exp;
    int          due;
    string       tag;
  } sb_t;
  sb_t sb[$];

  wb_gpio_if bus();

  wb_gpio #(
    .WIDTH       (16),
    .SYNC_STAGES (2),
    .OUT_RESET   (16'h0000)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb        (bus),
    .gpio_i    (gpio_in),
    .gpio_o    (gpio_out),
    .gpio_oe_o (gpio_oe),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.dat_w = '0; bus.sel = '0;
  endtask

  // Present one strobe at the current negedge and record its expected ack.
  task automatic drive(input logic we, input logic [3:0] off, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string tag);
    sb_t e;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
    bus.adr = BASE | {26'd0, off, 2'b00};
    bus.dat_w = dat; bus.sel = sel;
    e.rd = ~we; e.exp = exp; e.due = cyc_n + 1; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic sample();
    sb_t e;
    check("stall_err", {30'd0, bus.stall, bus.err}, 32'd0);
    if (bus.ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ack", {31'd0, bus.ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_ack_cycle"}, cyc_n, e.due);
        if (e.rd) check(e.tag, bus.dat_r, e.exp);
      end
    end else begin
      check("dat_idle", bus.dat_r, 32'd0);
      if (sb.size() != 0 && sb[0].due <= cyc_n) begin
        e = sb.pop_front();
        check({e.tag, "_ack_missing"}, {31'd0, bus.ack}, 32'd1);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel, input string tag);
    drive(1'b1, off, dat, sel, 32'd0, tag);
    tick();
    idle();
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string tag);
    drive(1'b0, off, 32'd0, 4'hF, exp, tag);
    tick();
    idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    // Asynchronous reset, asserted away from any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_gpio_o", {16'd0, gpio_out}, 32'h0000);
    check("rst_oe",     {16'd0, gpio_oe},  32'h0000);
    check("rst_irq",    {31'd0, irq},      32'd0);
    check("rst_ack",    {31'd0, bus.ack},  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Output register, byte lanes and atomic ops
    wr(4'd0, 32'hFFFF_00F0, 4'b0001, "wr_dout");
    check("gpio_o_f0", {16'd0, gpio_out}, 32'h00F0);
    rd(4'd0, 32'h0000_00F0, "rd_dout_f0");
    wr(4'd3, 32'h0003, 4'b0011, "wr_set");
    wr(4'd4, 32'h0010, 4'b0011, "wr_clr");
    wr(4'd5, 32'h8001, 4'b0011, "wr_tgl");
    check("gpio_o_80e2", {16'd0, gpio_out}, 32'h80E2);
    rd(4'd0, 32'h0000_80E2, "rd_dout_80e2");
    wr(4'd3, 32'h0100, 4'b0001, "wr_set_masked");
    rd(4'd0, 32'h0000_80E2, "rd_dout_masked");
    rd(4'd3, 32'h0, "rd_set_wo");

    // Direction register, bits above WIDTH ignored
    wr(4'd1, 32'hFFFF_A5A5, 4'b1111, "wr_dir");
    check("oe_a5a5", {16'd0, gpio_oe}, 32'hA5A5);
    rd(4'd1, 32'h0000_A5A5, "rd_dir");
    wr(4'd1, 32'h0, 4'b1111, "wr_dir0");
    check("oe_zero", {16'd0, gpio_oe}, 32'h0);

    // Strobe without cyc must not be acknowledged
    bus.cyc = 1'b0; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF;
    wait_cycles(2);
    idle();

    // Input latency: pin 3 rises together with the first of four reads
    gpio_in[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd2, 32'd0, 4'hF, (i < 2) ? 32'h0 : 32'h8, "rd_din_lat");
      tick();
    end
    idle();

    // Sub-cycle glitch between sampling edges is invisible
    gpio_in[5] = 1'b1;
    #3 gpio_in[5] = 1'b0;
    wait_cycles(4);
    rd(4'd2, 32'h0000_0008, "rd_din_glitch");

    // Rising-edge interrupt
    gpio_in[3] = 1'b0;
    wait_cycles(4);
    wr(4'd6, 32'h0008, 4'b0011, "wr_rise_en");
    rd(4'd6, 32'h0000_0008, "rd_rise_en");
    gpio_in[3] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("irq_latency", {31'd0, irq}, (i == 4) ? 32'd1 : 32'd0);
    end
    rd(4'd8, 32'h0000_0008, "rd_pend_rise");
    wr(4'd8, 32'h0008, 4'b0001, "wr_w1c");
    check("irq_ack_cycle", {31'd0, irq}, 32'd1);
    tick();
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rd(4'd8, 32'h0, "rd_pend_cleared");

    // Falling edge with FALL_EN = 0
    gpio_in[3] = 1'b0;
    wait_cycles(5);
    rd(4'd8, 32'h0, "rd_pend_nofall");
    check("irq_nofall", {31'd0, irq}, 32'd0);

    // Edge while disabled is not remembered
    wr(4'd6, 32'h0, 4'b0011, "wr_rise_dis");
    gpio_in[3] = 1'b1;
    wait_cycles(5);
    wr(4'd6, 32'h0008, 4'b0011, "wr_rise_reen");
    wait_cycles(2);
    rd(4'd8, 32'h0, "rd_pend_not_remembered");

    // Falling-edge interrupt, masked W1C, disabling keeps pending
    wr(4'd7, 32'h0008, 4'b0011, "wr_fall_en");
    gpio_in[3] = 1'b0;
    wait_cycles(5);
    rd(4'd8, 32'h0000_0008, "rd_pend_fall");
    wr(4'd8, 32'h0008, 4'b0010, "wr_w1c_masked");
    rd(4'd8, 32'h0000_0008, "rd_pend_masked_w1c");
    wr(4'd7, 32'h0, 4'b0011, "wr_fall_dis");
    rd(4'd8, 32'h0000_0008, "rd_pend_kept");

    // Set-wins: W1C accepted on the edge where the new rise is captured
    gpio_in[3] = 1'b1;
    tick();
    tick();
    drive(1'b1, 4'd8, 32'h0008, 4'b0001, 32'd0, "wr_w1c_collide");
    tick();
    idle();
    rd(4'd8, 32'h0000_0008, "rd_pend_setwins");
    wr(4'd8, 32'h0008, 4'b0001, "wr_w1c_final");
    rd(4'd8, 32'h0, "rd_pend_final");

    // Pipelined back-to-back accesses including unmapped offsets
    drive(1'b0, 4'd0,  32'd0,          4'hF,    32'h0000_80E2, "pipe_rd0");
    tick();
    drive(1'b1, 4'd0,  32'h0000_1234,  4'b0011, 32'd0,         "pipe_wr0");
    tick();
    drive(1'b0, 4'd12, 32'd0,          4'hF,    32'h0,         "pipe_rd12");
    tick();
    drive(1'b1, 4'd15, 32'hFFFF_FFFF,  4'hF,    32'd0,         "pipe_wr15");
    tick();
    idle();
    rd(4'd0, 32'h0000_1234, "rd_dout_1234");
    rd(4'd1, 32'h0, "rd_dir_after15");
    rd(4'd6, 32'h0000_0008, "rd_rise_after15");
    check("gpio_o_1234", {16'd0, gpio_out}, 32'h1234);

    // Write then read in consecutive cycles
    wr(4'd0, 32'h0000_5555, 4'b0011, "wr_dout_5555");
    rd(4'd0, 32'h0000_5555, "rd_dout_b2b");

    // Async reset in the middle of an acknowledged read
    wr(4'd1, 32'h0000_00FF, 4'b0001, "wr_dir_ff");
    wr(4'd7, 32'h0008, 4'b0011, "wr_fall_en2");
    gpio_in[3] = 1'b0;
    wait_cycles(5);
    check("irq_before_rst", {31'd0, irq}, 32'd1);
    drive(1'b0, 4'd0, 32'd0, 4'hF, 32'h0000_5555, "rd_killed");
    @(posedge clk);
    #1 check("ack_before_rst", {31'd0, bus.ack}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ack",    {31'd0, bus.ack},  32'd0);
    check("mid_rst_dat",    bus.dat_r,         32'd0);
    check("mid_rst_gpio_o", {16'd0, gpio_out}, 32'h0000);
    check("mid_rst_oe",     {16'd0, gpio_oe},  32'h0000);
    check("mid_rst_irq",    {31'd0, irq},      32'd0);
    sb.delete();
    @(negedge clk);
    idle();
    rst = 1'b0;
    rd(4'd0, 32'h0, "rd_dout_after_rst");
    rd(4'd8, 32'h0, "rd_pend_after_rst");
    rd(4'd7, 32'h0, "rd_fall_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_gpio.md
Name: wb_gpio

Overview:
Wishbone B4 pipelined slave providing a general-purpose I/O port. It sits on crossbar slave port "gpioa" at base 0x02000000, mask 0xFFFFFFC0 (64-byte window). Each pin has:
- an output register with per-pin direction;
- an atomic set/clear/toggle register;
- a two-flop input synchroniser;
- rising/falling edge detection feeding a level interrupt toward the CPU IRQ vector.

Parameters:
WIDTH, 16, number of GPIO pins (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)
OUT_RESET, 0, reset value of the output data register (WIDTH bits)

Ports:
clk_i  in  1  Wishbone/system clock
rst_i  in  1  asynchronous active-high reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  byte address; only [5:2] decoded
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte lanes
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_stall_o  out  1  stall, tied 0
wb_err_o  out  1  error, tied 0
gpio_i  in  WIDTH  asynchronous pin inputs
gpio_o  out  WIDTH  output data
gpio_oe_o  out  WIDTH  output enable (1 = drive)
irq_o  out  1  OR of (IRQ_PEND) bits, registered

Behaviour:
- Clock/reset: one clock, clk_i. rst_i is asynchronous, active-high. All state is reset by rst_i; nothing else clears state.
- Reset values:
  - gpio_o = OUT_RESET; gpio_oe_o = 0; irq_o = 0.
  - wb_ack_o = 0; wb_dat_o = 0.
  - Synchroniser and edge-history flops = 0.
  - IRQ_RISE_EN = IRQ_FALL_EN = IRQ_PEND = 0.
- Handshake:
  - wb_stall_o is always 0, so every cyc&stb cycle is accepted.
  - wb_ack_o is asserted exactly one cycle after each accepted strobe. Back-to-back strobes give back-to-back acks.
  - If wb_cyc_i drops, no further acks are issued for strobes not yet accepted. An ack already scheduled may still appear.
  - Read data is valid in the ack cycle. wb_dat_o = 0 whenever ack is low.
- Register map (word offset adr[5:2]):
  - 0 DATA_OUT (RW)
  - 1 DIR (RW, 1 = output)
  - 2 DATA_IN (RO, synchronised pins)
  - 3 SET (WO): DATA_OUT |= d
  - 4 CLR (WO): DATA_OUT &= ~d
  - 5 TGL (WO): DATA_OUT ^= d
  - 6 IRQ_RISE_EN (RW)
  - 7 IRQ_FALL_EN (RW)
  - 8 IRQ_PEND (R, W1C)
  - 9..15: reads return 0, writes are ignored.
  - WO registers read as 0. Bits at or above WIDTH read 0 and ignore writes.
- Byte lanes: wb_sel_i gates writes per byte. For SET/CLR/TGL/W1C, masked-off bytes are treated as zero.
- Write timing: a register updates on the clock edge that accepts the write. It is visible on gpio_o/gpio_oe_o in the same cycle the ack is high.
- Read timing: a read captures register contents at the accept edge. A write and a read in consecutive cycles return the new value.
- Input path:
  - sync = SYNC_STAGES flop chain of gpio_i; DATA_IN = last stage.
  - prev = DATA_IN delayed one cycle.
  - rise = DATA_IN & ~prev & RISE_EN; fall = ~DATA_IN & prev & FALL_EN.
  - Pin-change to DATA_IN latency = SYNC_STAGES cycles. Pin-change to PEND set = SYNC_STAGES+1 cycles. irq_o asserts one cycle later.
- Pending update: PEND_next = (PEND & ~w1c_mask) | rise | fall. An edge arriving in the same cycle as its W1C clear leaves the bit set (set wins).
- Enable changes: clearing an enable does not clear already-pending bits. Edges are not detected while an enable is 0, and are not remembered for later.
- Pin direction: pins are sampled regardless of DIR, so loopback of driven outputs is observable.
- Reset mid-transaction: ack drops immediately (asynchronously), the pending access is discarded, and the master must retry.

Decomposition:
- Package gpio_pkg holds:
  - the register offset constants (GPIO_DATA_OUT..GPIO_IRQ_PEND, as 4-bit word indices);
  - an enum gpio_reg_e;
  - a function applying the sel_i byte mask to a 32-bit word.
- One sub-module, gpio_sync_edge: a parameterised synchroniser plus edge detector, per WIDTH vector. It outputs DATA_IN, rise and fall.

Test Plan:
- Reset values: assert rst_i mid-cycle -> gpio_o = OUT_RESET, gpio_oe_o = 0, irq_o = 0, ack = 0 within the same cycle, asynchronously.
- Output writes: write DATA_OUT = 0x00F0, sel = 4'b0001 -> reads back 0x00F0. Then SET 0x0003, CLR 0x0010, TGL 0x8001 -> DATA_OUT reads 0x80E2. Each write acks exactly one cycle after stb.
- Input latency: DIR = 0, toggle gpio_i[3] 0->1 -> DATA_IN bit 3 reads 1 starting SYNC_STAGES cycles later. A glitch shorter than one clock that misses a sampling edge produces no change.
- Edge interrupt: RISE_EN = 0x0008, pulse gpio_i[3] high -> PEND = 0x0008 and irq_o = 1 at SYNC_STAGES+2 cycles. W1C 0x0008 -> irq_o = 0 next cycle. Falling edge with FALL_EN = 0 -> no PEND.
- Set-wins collision: time a W1C of bit 3 to land in the same cycle as a new rising edge on pin 3 -> PEND bit 3 stays 1.
- Pipelined and unmapped access: four back-to-back strobes (read, write, read offset 12, write offset 15) -> four consecutive acks. The offset-12 read returns 0; the offset-15 write has no effect. stall and err stay 0 throughout.
